// File: rtl/pipelined_adder_if.sv
// Operand/result stream interface for the segmented pipelined adder.
interface pipelined_adder_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] SUM;
  logic             cout;
  logic             ovf;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, A, B, cin, sub, out_ready,
    input  in_ready, out_valid, SUM, cout, ovf
  );

  // The adder itself.
  modport slave (
    input  in_valid, A, B, cin, sub, out_ready,
    output in_ready, out_valid, SUM, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// Segmented pipelined adder/subtractor: one SEG-bit carry segment per stage,
// with a single global stall that freezes every stage while the output waits.
module pipelined_adder #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SEG   = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipelined_adder_if.slave bus
);
  localparam int unsigned STAGES = WIDTH / SEG;
  localparam int unsigned LAST   = STAGES - 1;

  if ((WIDTH % SEG) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of SEG");
  end

  logic             stall;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Subtraction is A + ~B + 1; cin only matters for addition.
  assign b_eff  = bus.sub ? ~bus.B : bus.B;
  assign c_eff  = bus.sub | bus.cin;
  assign stall  = g_stage[LAST].v_q & ~bus.out_ready;
  assign accept = bus.in_valid & ~stall;

  // Stage k adds segment k; operand bits above it ride along, finished sum
  // bits below it ride along, so every register is exactly as wide as needed.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned IN_W = WIDTH - k * SEG;
    localparam int unsigned LO_W = (k + 1) * SEG;

    logic            v_in;
    logic            c_in;
    logic [IN_W-1:0] a_in;
    logic [IN_W-1:0] b_in;
    logic [SEG:0]    seg_sum;
    logic [LO_W-1:0] s_nxt;
    logic            v_q;
    logic            c_q;
    logic [LO_W-1:0] s_q;

    if (k == 0) begin : g_src
      assign v_in  = accept;
      assign c_in  = c_eff;
      assign a_in  = bus.A;
      assign b_in  = b_eff;
      assign s_nxt = seg_sum[SEG-1:0];
    end else begin : g_src
      assign v_in  = g_stage[k-1].v_q;
      assign c_in  = g_stage[k-1].c_q;
      assign a_in  = g_stage[k-1].g_fwd.a_q;
      assign b_in  = g_stage[k-1].g_fwd.b_q;
      assign s_nxt = {seg_sum[SEG-1:0], g_stage[k-1].s_q};
    end

    assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + (SEG+1)'(c_in);

    // Stage valid, segment carry and accumulated low sum bits.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (!stall) begin
        v_q <= v_in;
        c_q <= seg_sum[SEG];
        s_q <= s_nxt;
      end
    end

    if (k < LAST) begin : g_fwd
      logic [IN_W-SEG-1:0] a_q;
      logic [IN_W-SEG-1:0] b_q;

      // Delay registers for the operand segments not yet added.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= a_in[IN_W-1:SEG];
          b_q <= b_in[IN_W-1:SEG];
        end
      end
    end else begin : g_ovf
      logic ovf_q;

      // Signed overflow: carry into the MSB xor carry out of the MSB.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (!stall) begin
          ovf_q <= a_in[SEG-1] ^ b_in[SEG-1] ^ seg_sum[SEG-1] ^ seg_sum[SEG];
        end
      end
    end
  end

  assign bus.in_ready  = ~stall;
  assign bus.out_valid = g_stage[LAST].v_q;
  assign bus.SUM       = g_stage[LAST].s_q;
  assign bus.cout      = g_stage[LAST].c_q;
  assign bus.ovf       = g_stage[LAST].g_ovf.ovf_q;

endmodule
